// File: rtl/dds_pkg.sv
// Shared DDS definitions: NCO phase width and the sweep controller state encoding.
package dds_pkg;

    localparam int PHASE_W = 14;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DWELL = 2'd2,
        ST_DONE  = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/dds_dwell_cnt.sv
// Loadable down-counter; tc is high while the count sits at zero.
module dds_dwell_cnt #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          en,
    input  logic [CW-1:0] load_val,
    output logic          tc
);

    logic [CW-1:0] count;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - CW'(1);
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// Linear up-chirp controller: steps the NCO phase increment from start to stop,
// holding each value for a programmable dwell, single-shot or auto-repeat.
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int PW = PHASE_W,
    parameter int CW = 16
) (
    input  logic          I_clk,
    input  logic          I_rst_n,
    input  logic          I_start,
    input  logic          I_abort,
    input  logic          I_repeat,
    input  logic [PW-1:0] I_init_phase,
    input  logic [PW-1:0] I_start_inc,
    input  logic [PW-1:0] I_stop_inc,
    input  logic [PW-1:0] I_step_inc,
    input  logic [CW-1:0] I_dwell,
    output logic [PW-1:0] O_init_phase,
    output logic [PW-1:0] O_inc_phase,
    output logic          O_change_phase,
    output logic          O_busy,
    output logic          O_done
);

    sweep_state_e  state, state_nxt;

    logic [PW-1:0] cfg_init, cfg_start, cfg_stop, cfg_step;
    logic [CW-1:0] cfg_dwell_m1;

    logic          load_cfg;
    logic          cnt_load, cnt_en, cnt_tc;
    logic [CW-1:0] cnt_load_val;

    logic [PW-1:0] inc_nxt, init_nxt, next_inc;
    logic [PW:0]   sum;

    // The dwell counter holds the cycles remaining after the current one.
    function automatic logic [CW-1:0] dwell_m1(input logic [CW-1:0] d);
        return (d == '0) ? '0 : d - CW'(1);
    endfunction

    dds_dwell_cnt #(.CW(CW)) u_dwell_cnt (
        .clk      (I_clk),
        .rst_n    (I_rst_n),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_load_val),
        .tc       (cnt_tc)
    );

    // Carry out or overshoot both clamp to stop, so the sweep never wraps.
    assign sum      = {1'b0, O_inc_phase} + {1'b0, cfg_step};
    assign next_inc = ((cfg_step == '0) || sum[PW] || (sum[PW-1:0] > cfg_stop))
                      ? cfg_stop : sum[PW-1:0];

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_nxt    = state;
        load_cfg     = 1'b0;
        cnt_load     = 1'b0;
        cnt_en       = 1'b0;
        cnt_load_val = cfg_dwell_m1;
        inc_nxt      = O_inc_phase;
        init_nxt     = O_init_phase;

        if (I_abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (I_start) begin
                        state_nxt    = ST_LOAD;
                        load_cfg     = 1'b1;
                        cnt_load     = 1'b1;
                        cnt_load_val = dwell_m1(I_dwell);
                        inc_nxt      = I_start_inc;
                        init_nxt     = I_init_phase;
                    end
                end
                ST_LOAD, ST_DWELL: begin
                    if (!cnt_tc) begin
                        state_nxt = ST_DWELL;
                        cnt_en    = 1'b1;
                    end else if (O_inc_phase >= cfg_stop) begin
                        state_nxt = ST_DONE;
                    end else begin
                        state_nxt = ST_DWELL;
                        cnt_load  = 1'b1;
                        inc_nxt   = next_inc;
                    end
                end
                ST_DONE: begin
                    if (I_repeat) begin
                        state_nxt = ST_LOAD;
                        cnt_load  = 1'b1;
                        inc_nxt   = cfg_start;
                        init_nxt  = cfg_init;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            cfg_init     <= '0;
            cfg_start    <= '0;
            cfg_stop     <= '0;
            cfg_step     <= '0;
            cfg_dwell_m1 <= '0;
        end else if (load_cfg) begin
            cfg_init     <= I_init_phase;
            cfg_start    <= I_start_inc;
            cfg_stop     <= I_stop_inc;
            cfg_step     <= I_step_inc;
            cfg_dwell_m1 <= dwell_m1(I_dwell);
        end
    end

    // Outputs are registered from the next-state decode, so they track the state exactly.
    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            O_init_phase   <= '0;
            O_inc_phase    <= '0;
            O_change_phase <= 1'b0;
            O_busy         <= 1'b0;
            O_done         <= 1'b0;
        end else begin
            O_init_phase   <= init_nxt;
            O_inc_phase    <= inc_nxt;
            O_change_phase <= (state_nxt == ST_LOAD);
            O_busy         <= (state_nxt != ST_IDLE);
            O_done         <= (state_nxt == ST_DONE);
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Scoreboard bench for dds_sweep_ctrl: a sweep model fills a queue of per-cycle
// expectations and a monitor compares them while the DUT reports busy.
module tb_dds_sweep_ctrl;

    logic        clk;
    logic        rst_n;
    logic        start, abort_i, repeat_i;
    logic [13:0] init_phase, start_inc, stop_inc, step_inc;
    logic [15:0] dwell;
    logic [13:0] o_init, o_inc;
    logic        o_chg, o_busy, o_done;

    typedef struct {
        int inc;
        bit chg;
        bit done;
        int init;
    } rec_t;

    rec_t sq[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    dds_sweep_ctrl #(.PW(14), .CW(16)) dut (
        .I_clk          (clk),
        .I_rst_n        (rst_n),
        .I_start        (start),
        .I_abort        (abort_i),
        .I_repeat       (repeat_i),
        .I_init_phase   (init_phase),
        .I_start_inc    (start_inc),
        .I_stop_inc     (stop_inc),
        .I_step_inc     (step_inc),
        .I_dwell        (dwell),
        .O_init_phase   (o_init),
        .O_inc_phase    (o_inc),
        .O_change_phase (o_chg),
        .O_busy         (o_busy),
        .O_done         (o_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every busy cycle must match the next expected record.
    initial begin
        rec_t r;
        forever begin
            @(negedge clk);
            if (rst_n && o_busy) begin
                if (sq.size() == 0) begin
                    check("unexpected_busy", 1, 0);
                end else begin
                    r = sq.pop_front();
                    check("inc_phase", int'(o_inc), r.inc);
                    check("change_phase", int'(o_chg), int'(r.chg));
                    check("done", int'(o_done), int'(r.done));
                    check("init_phase", int'(o_init), r.init);
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    task automatic scramble_cfg();
        init_phase = 14'($urandom);
        start_inc  = 14'($urandom);
        stop_inc   = 14'($urandom);
        step_inc   = 14'($urandom);
        dwell      = 16'($urandom_range(0, 5));
    endtask

    // Runs one sweep request. abort_at / rst_at < 0 disable those events;
    // both are cycle indices counted from the LOAD cycle.
    task automatic run_sweep(input int c_init, input int c_start, input int c_stop,
                             input int c_step, input int c_dwell, input int loops,
                             input int abort_at, input int rst_at);
        rec_t seq[$];
        int   d, v, len, total, last, exp_inc;
        d = (c_dwell == 0) ? 1 : c_dwell;
        v = c_start;
        while (1) begin
            for (int i = 0; i < d; i++)
                seq.push_back('{inc: v, chg: (seq.size() == 0), done: 1'b0, init: c_init});
            if (v >= c_stop) break;
            v = (c_step == 0 || v + c_step > c_stop) ? c_stop : v + c_step;
        end
        seq.push_back('{inc: v, chg: 1'b0, done: 1'b1, init: c_init});
        len   = seq.size();
        total = len * loops;
        last  = total;
        if (abort_at >= 0 && abort_at < last) last = abort_at + 1;
        if (rst_at >= 0 && rst_at < last) last = rst_at;
        for (int k = 0; k < last; k++) sq.push_back(seq[k % len]);
        exp_inc = seq[(last - 1) % len].inc;

        @(posedge clk); #1;
        init_phase = 14'(c_init);
        start_inc  = 14'(c_start);
        stop_inc   = 14'(c_stop);
        step_inc   = 14'(c_step);
        dwell      = 16'(c_dwell);
        start      = 1'b1;
        abort_i    = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;

        for (int k = 0; k < total; k++) begin
            scramble_cfg();
            start    = ($urandom_range(0, 5) == 0);
            repeat_i = (k < len * (loops - 1));
            abort_i  = (k == abort_at);
            if (k == rst_at) begin
                #2;
                rst_n = 1'b0;
                #1;
                check("rst_busy", int'(o_busy), 0);
                check("rst_inc", int'(o_inc), 0);
                check("rst_init", int'(o_init), 0);
                check("rst_chg_done", int'({o_chg, o_done}), 0);
                #3;
                rst_n    = 1'b1;
                start    = 1'b0;
                abort_i  = 1'b0;
                repeat_i = 1'b0;
                repeat (3) @(posedge clk);
                #1;
                check("post_rst_busy", int'(o_busy), 0);
                check("post_rst_inc", int'(o_inc), 0);
                check("post_rst_queue", sq.size(), 0);
                return;
            end
            @(posedge clk); #1;
            if (k == abort_at) break;
        end
        start    = 1'b0;
        abort_i  = 1'b0;
        repeat_i = 1'b0;
        check("end_busy", int'(o_busy), 0);
        check("end_chg_done", int'({o_chg, o_done}), 0);
        check("end_inc_hold", int'(o_inc), exp_inc);
        check("end_queue", sq.size(), 0);
    endtask

    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        abort_i  = 1'b0;
        repeat_i = 1'b0;
        init_phase = '0; start_inc = '0; stop_inc = '0; step_inc = '0; dwell = '0;
        #3;
        check("reset_busy", int'(o_busy), 0);
        check("reset_inc", int'(o_inc), 0);
        check("reset_chg_done", int'({o_chg, o_done}), 0);
        #9;
        rst_n = 1'b1;

        // Basic chirp, then clamp on overflow and on overshoot
        run_sweep(123, 100, 250, 50, 3, 1, -1, -1);
        run_sweep(7, 16000, 16383, 1000, 1, 1, -1, -1);
        run_sweep(55, 100, 250, 100, 2, 1, -1, -1);

        // Abort inside the second dwell holds 150; then a same-cycle start+abort is a no-op
        run_sweep(9, 100, 250, 50, 3, 1, 4, -1);
        @(posedge clk); #1;
        start_inc = 14'd999; stop_inc = 14'd1200; step_inc = 14'd1; dwell = 16'd1;
        start = 1'b1; abort_i = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort_i = 1'b0;
        check("start_abort_busy", int'(o_busy), 0);
        check("start_abort_chg", int'(o_chg), 0);
        check("start_abort_inc", int'(o_inc), 150);

        // Auto-repeat with dwell 0, three loops
        run_sweep(300, 10, 20, 5, 0, 3, -1, -1);

        // Asynchronous reset mid-sweep
        run_sweep(1000, 100, 400, 30, 2, 1, -1, 5);

        // Start above stop, and zero step
        run_sweep(11, 300, 200, 5, 4, 1, -1, -1);
        run_sweep(12, 10, 40, 0, 2, 1, -1, -1);

        // Randomized sweeps
        for (int t = 0; t < 30; t++) begin
            int s, e, st, dw, lp, ab;
            s  = $urandom_range(0, 16383);
            if ($urandom_range(0, 3) == 0) e = $urandom_range(0, s);
            else e = (s + $urandom_range(0, 150) > 16383) ? 16383 : s + $urandom_range(0, 150);
            st = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 16383) : $urandom_range(0, 40);
            dw = $urandom_range(0, 3);
            lp = $urandom_range(1, 2);
            ab = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : -1;
            run_sweep($urandom_range(0, 16383), s, e, st, dw, lp, ab, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
